// File: rtl/load_store_agu.sv
// load_store_agu
// Load/store address-generation stage sitting directly in front of data_mem.
// It takes one issued load/store op per cycle from the reservation station and
// computes EA = (ra_zero ? 0 : ra_value) + offset, modulo 2^32. It builds
// left-justified big-endian byte-lane masks and aligned store data, then holds
// the access in a one-entry MEM slot toward data_mem.
// Update forms (lbzu/stwu/...) also load a one-entry UPD slot that writes EA
// back to rA. The two slots drain independently.
//
// Big-endian numbering is used on the address, data and lane ports (bit 0 = MSB,
// lane 0 = byte at EA).
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   input_valid/input_ready   issue handshake from the reservation station
//   rs_id_in, result_reg_addr_in, ra_addr_in
//                             op tag, rD (loads) and rA field
//   op_load, op_size, op_update, ra_zero
//                             op decode
//   ra_value, offset, store_data
//                             operands
//   mem_*                     MEM slot / data_mem input handshake and payload
//   upd_*                     UPD slot / rA update writeback handshake and payload
module load_store_agu #(
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic [4:0]             ra_addr_in,
    input  logic                   op_load,
    input  logic [1:0]             op_size,
    input  logic                   op_update,
    input  logic                   ra_zero,
    input  logic [0:31]            ra_value,
    input  logic [0:31]            offset,
    input  logic [0:31]            store_data,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [RS_ID_WIDTH-1:0] mem_rs_id,
    output logic [4:0]             mem_result_reg_addr,
    output logic [0:31]            mem_address,
    output logic [0:3]             mem_write_en,
    output logic [0:31]            mem_write_data,
    output logic [0:3]             mem_read_en,
    output logic                   upd_valid,
    input  logic                   upd_ready,
    output logic [RS_ID_WIDTH-1:0] upd_rs_id,
    output logic [4:0]             upd_reg_addr,
    output logic [0:31]            upd_value
);

    // Byte-lane mask, left-justified: lane 0 is the byte at EA.
    // The reserved size code behaves as a word.
    function automatic logic [0:3] lane_mask(input logic [1:0] size);
        case (size)
            2'b00:   lane_mask = 4'b1000;
            2'b01:   lane_mask = 4'b1100;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Move the low-order byte/half of rS into the leading lanes.
    function automatic logic [0:31] align_store(input logic [1:0] size,
                                                input logic [0:31] sd);
        case (size)
            2'b00:   align_store = {sd[24:31], 24'b0};
            2'b01:   align_store = {sd[16:31], 16'b0};
            default: align_store = sd;
        endcase
    endfunction

    logic                   mem_vld_p1_q,   mem_vld_p1_d;
    logic [RS_ID_WIDTH-1:0] mem_rs_id_p1_q, mem_rs_id_p1_d;
    logic [4:0]             mem_rd_p1_q,    mem_rd_p1_d;
    logic [0:31]            mem_addr_p1_q,  mem_addr_p1_d;
    logic [0:3]             mem_wen_p1_q,   mem_wen_p1_d;
    logic [0:31]            mem_wdat_p1_q,  mem_wdat_p1_d;
    logic [0:3]             mem_ren_p1_q,   mem_ren_p1_d;

    logic                   upd_vld_p1_q,   upd_vld_p1_d;
    logic [RS_ID_WIDTH-1:0] upd_rs_id_p1_q, upd_rs_id_p1_d;
    logic [4:0]             upd_ra_p1_q,    upd_ra_p1_d;
    logic [0:31]            upd_val_p1_q,   upd_val_p1_d;

    logic [0:31] base_p0;
    logic [0:31] ea_p0;
    logic [0:3]  mask_p0;
    logic        accept_p0;
    logic        upd_load_p0;

    // Stage p0: EA, lane mask and acceptance, all combinational on the issue slot.
    // Each slot may take a new op if it is empty or draining this cycle.
    assign input_ready = (!mem_vld_p1_q || mem_ready) && (!upd_vld_p1_q || upd_ready);
    assign accept_p0   = input_valid && input_ready;
    // Update with rA = 0 is an invalid form: the access is still performed, the
    // writeback is suppressed.
    assign upd_load_p0 = accept_p0 && op_update && !ra_zero;

    assign base_p0 = ra_zero ? 32'h0 : ra_value;
    assign ea_p0   = base_p0 + offset;    // carry out discarded: modulo 2^32
    assign mask_p0 = lane_mask(op_size);

    always_comb begin
        mem_vld_p1_d   = mem_vld_p1_q;
        mem_rs_id_p1_d = mem_rs_id_p1_q;
        mem_rd_p1_d    = mem_rd_p1_q;
        mem_addr_p1_d  = mem_addr_p1_q;
        mem_wen_p1_d   = mem_wen_p1_q;
        mem_wdat_p1_d  = mem_wdat_p1_q;
        mem_ren_p1_d   = mem_ren_p1_q;
        upd_vld_p1_d   = upd_vld_p1_q;
        upd_rs_id_p1_d = upd_rs_id_p1_q;
        upd_ra_p1_d    = upd_ra_p1_q;
        upd_val_p1_d   = upd_val_p1_q;

        // Reload takes priority over drain so back-to-back ops keep full throughput.
        if (accept_p0) begin
            mem_vld_p1_d   = 1'b1;
            mem_rs_id_p1_d = rs_id_in;
            mem_rd_p1_d    = result_reg_addr_in;
            mem_addr_p1_d  = ea_p0;
            mem_wen_p1_d   = op_load ? 4'b0000 : mask_p0;
            mem_ren_p1_d   = op_load ? mask_p0 : 4'b0000;
            mem_wdat_p1_d  = op_load ? 32'h0 : align_store(op_size, store_data);
        end else if (mem_vld_p1_q && mem_ready) begin
            mem_vld_p1_d   = 1'b0;
        end

        if (upd_load_p0) begin
            upd_vld_p1_d   = 1'b1;
            upd_rs_id_p1_d = rs_id_in;
            upd_ra_p1_d    = ra_addr_in;
            upd_val_p1_d   = ea_p0;
        end else if (upd_vld_p1_q && upd_ready) begin
            upd_vld_p1_d   = 1'b0;
        end
    end

    // Stage p1: output slots. Reset discards both slots and clears their payloads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_vld_p1_q   <= 1'b0;
            mem_rs_id_p1_q <= '0;
            mem_rd_p1_q    <= '0;
            mem_addr_p1_q  <= '0;
            mem_wen_p1_q   <= '0;
            mem_wdat_p1_q  <= '0;
            mem_ren_p1_q   <= '0;
            upd_vld_p1_q   <= 1'b0;
            upd_rs_id_p1_q <= '0;
            upd_ra_p1_q    <= '0;
            upd_val_p1_q   <= '0;
        end else begin
            mem_vld_p1_q   <= mem_vld_p1_d;
            mem_rs_id_p1_q <= mem_rs_id_p1_d;
            mem_rd_p1_q    <= mem_rd_p1_d;
            mem_addr_p1_q  <= mem_addr_p1_d;
            mem_wen_p1_q   <= mem_wen_p1_d;
            mem_wdat_p1_q  <= mem_wdat_p1_d;
            mem_ren_p1_q   <= mem_ren_p1_d;
            upd_vld_p1_q   <= upd_vld_p1_d;
            upd_rs_id_p1_q <= upd_rs_id_p1_d;
            upd_ra_p1_q    <= upd_ra_p1_d;
            upd_val_p1_q   <= upd_val_p1_d;
        end
    end

    assign mem_valid           = mem_vld_p1_q;
    assign mem_rs_id           = mem_rs_id_p1_q;
    assign mem_result_reg_addr = mem_rd_p1_q;
    assign mem_address         = mem_addr_p1_q;
    assign mem_write_en        = mem_wen_p1_q;
    assign mem_write_data      = mem_wdat_p1_q;
    assign mem_read_en         = mem_ren_p1_q;
    assign upd_valid           = upd_vld_p1_q;
    assign upd_rs_id           = upd_rs_id_p1_q;
    assign upd_reg_addr        = upd_ra_p1_q;
    assign upd_value           = upd_val_p1_q;

endmodule

// File: tb/tb_load_store_agu.sv
module tb_load_store_agu;

    logic        clk = 1'b0;
    logic        rst;
    logic        input_valid;
    logic        input_ready;
    logic [4:0]  rs_id_in;
    logic [4:0]  result_reg_addr_in;
    logic [4:0]  ra_addr_in;
    logic        op_load;
    logic [1:0]  op_size;
    logic        op_update;
    logic        ra_zero;
    logic [0:31] ra_value;
    logic [0:31] offset;
    logic [0:31] store_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rs_id;
    logic [4:0]  mem_result_reg_addr;
    logic [0:31] mem_address;
    logic [0:3]  mem_write_en;
    logic [0:31] mem_write_data;
    logic [0:3]  mem_read_en;
    logic        upd_valid;
    logic        upd_ready;
    logic [4:0]  upd_rs_id;
    logic [4:0]  upd_reg_addr;
    logic [0:31] upd_value;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_store_agu #(.RS_ID_WIDTH(5)) dut (
        .clk                (clk),
        .rst                (rst),
        .input_valid        (input_valid),
        .input_ready        (input_ready),
        .rs_id_in           (rs_id_in),
        .result_reg_addr_in (result_reg_addr_in),
        .ra_addr_in         (ra_addr_in),
        .op_load            (op_load),
        .op_size            (op_size),
        .op_update          (op_update),
        .ra_zero            (ra_zero),
        .ra_value           (ra_value),
        .offset             (offset),
        .store_data         (store_data),
        .mem_valid          (mem_valid),
        .mem_ready          (mem_ready),
        .mem_rs_id          (mem_rs_id),
        .mem_result_reg_addr(mem_result_reg_addr),
        .mem_address        (mem_address),
        .mem_write_en       (mem_write_en),
        .mem_write_data     (mem_write_data),
        .mem_read_en        (mem_read_en),
        .upd_valid          (upd_valid),
        .upd_ready          (upd_ready),
        .upd_rs_id          (upd_rs_id),
        .upd_reg_addr       (upd_reg_addr),
        .upd_value          (upd_value)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present an op on the issue slot (held until changed).
    task automatic drive_op(input logic [4:0] id, input logic [4:0] rd, input logic [4:0] ra_a,
                            input logic ld, input logic [1:0] sz, input logic upd,
                            input logic rz, input logic [31:0] ra, input logic [31:0] off,
                            input logic [31:0] sd);
        input_valid        = 1'b1;
        rs_id_in           = id;
        result_reg_addr_in = rd;
        ra_addr_in         = ra_a;
        op_load            = ld;
        op_size            = sz;
        op_update          = upd;
        ra_zero            = rz;
        ra_value           = ra;
        offset             = off;
        store_data         = sd;
    endtask

    // Advance one cycle and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        input_valid = 1'b0;
        rs_id_in = '0; result_reg_addr_in = '0; ra_addr_in = '0;
        op_load = 1'b0; op_size = 2'b00; op_update = 1'b0; ra_zero = 1'b0;
        ra_value = '0; offset = '0; store_data = '0;
        mem_ready = 1'b1; upd_ready = 1'b1;

        step(); step();
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_upd_valid", {31'b0, upd_valid}, 32'd0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_wdata", mem_write_data, 32'h0);
        chk("rst_mem_ren", {28'b0, mem_read_en}, 32'h0);
        chk("rst_upd_value", upd_value, 32'h0);
        rst = 1'b1;
        #1;
        chk("rst_input_ready", {31'b0, input_ready}, 32'd1);

        // lwz ra=0x1000 off=0x10
        drive_op(5'd1, 5'd7, 5'd2, 1'b1, 2'b10, 1'b0, 1'b0, 32'h1000, 32'h10, 32'hDEADBEEF);
        step();
        input_valid = 1'b0;
        chk("lwz_valid", {31'b0, mem_valid}, 32'd1);
        chk("lwz_addr", mem_address, 32'h1010);
        chk("lwz_ren", {28'b0, mem_read_en}, 32'hF);
        chk("lwz_wen", {28'b0, mem_write_en}, 32'h0);
        chk("lwz_wdata", mem_write_data, 32'h0);
        chk("lwz_rsid", {27'b0, mem_rs_id}, 32'd1);
        chk("lwz_rd", {27'b0, mem_result_reg_addr}, 32'd7);
        chk("lwz_no_upd", {31'b0, upd_valid}, 32'd0);
        step();
        chk("lwz_drained", {31'b0, mem_valid}, 32'd0);

        // stb sd=0xAABBCCDD EA=0x2003
        drive_op(5'd2, 5'd0, 5'd4, 1'b0, 2'b00, 1'b0, 1'b0, 32'h2000, 32'h3, 32'hAABBCCDD);
        step();
        input_valid = 1'b0;
        chk("stb_addr", mem_address, 32'h2003);
        chk("stb_wen", {28'b0, mem_write_en}, 32'h8);
        chk("stb_wdata", mem_write_data, 32'hDD000000);
        chk("stb_ren", {28'b0, mem_read_en}, 32'h0);

        // sthu ra=0xFFFFFFFE off=4 ra_addr=3 -> wraps to 2
        drive_op(5'd3, 5'd0, 5'd3, 1'b0, 2'b01, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h4, 32'h12345678);
        step();
        input_valid = 1'b0;
        chk("sthu_addr", mem_address, 32'h2);
        chk("sthu_wen", {28'b0, mem_write_en}, 32'hC);
        chk("sthu_wdata", mem_write_data, 32'h56780000);
        chk("sthu_upd_valid", {31'b0, upd_valid}, 32'd1);
        chk("sthu_upd_value", upd_value, 32'h2);
        chk("sthu_upd_ra", {27'b0, upd_reg_addr}, 32'd3);
        chk("sthu_upd_rsid", {27'b0, upd_rs_id}, 32'd3);
        step();
        chk("sthu_upd_drained", {31'b0, upd_valid}, 32'd0);

        // lbzu with ra_zero: access done, update suppressed
        drive_op(5'd4, 5'd9, 5'd0, 1'b1, 2'b00, 1'b1, 1'b1, 32'h5555, 32'h40, 32'h0);
        step();
        input_valid = 1'b0;
        chk("lbzu_rz_addr", mem_address, 32'h40);
        chk("lbzu_rz_ren", {28'b0, mem_read_en}, 32'h8);
        chk("lbzu_rz_upd", {31'b0, upd_valid}, 32'd0);

        // stw with reserved size, 0xFFFFFFFF + 1 wraps to 0
        drive_op(5'd12, 5'd0, 5'd1, 1'b0, 2'b11, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'hCAFEF00D);
        step();
        input_valid = 1'b0;
        chk("rsv_addr", mem_address, 32'h0);
        chk("rsv_wen", {28'b0, mem_write_en}, 32'hF);
        chk("rsv_wdata", mem_write_data, 32'hCAFEF00D);

        // data_mem stalls 3 cycles after accept; a second op waits on the issue slot
        step();
        mem_ready = 1'b0;
        drive_op(5'd5, 5'd1, 5'd0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0);
        step();
        drive_op(5'd6, 5'd2, 5'd0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", {31'b0, input_ready}, 32'd0);
            chk("stall_addr", mem_address, 32'h300);
            chk("stall_rsid", {27'b0, mem_rs_id}, 32'd5);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("stall_release_ready", {31'b0, input_ready}, 32'd1);
        step();
        input_valid = 1'b0;
        chk("stall_next_addr", mem_address, 32'h400);
        chk("stall_next_rsid", {27'b0, mem_rs_id}, 32'd6);
        step();

        // UPD backpressure blocks issue while MEM drains independently
        upd_ready = 1'b0;
        drive_op(5'd7, 5'd0, 5'd5, 1'b1, 2'b10, 1'b1, 1'b0, 32'h800, 32'h8, 32'h0);
        step();
        input_valid = 1'b0;
        chk("updbp_upd_value", upd_value, 32'h808);
        step();
        chk("updbp_mem_drained", {31'b0, mem_valid}, 32'd0);
        chk("updbp_upd_held", {31'b0, upd_valid}, 32'd1);
        chk("updbp_ready", {31'b0, input_ready}, 32'd0);
        upd_ready = 1'b1;
        step();
        chk("updbp_upd_drained", {31'b0, upd_valid}, 32'd0);

        // stream of 4 lwz, one per cycle, order preserved
        for (int k = 0; k < 4; k++) begin
            drive_op(5'(8 + k), 5'd0, 5'd0, 1'b1, 2'b10, 1'b0, 1'b0, 32'(32'h100 * (k + 1)), 32'h4, 32'h0);
            step();
            chk("stream_valid", {31'b0, mem_valid}, 32'd1);
            chk("stream_rsid", {27'b0, mem_rs_id}, 32'(8 + k));
            chk("stream_addr", mem_address, 32'(32'h100 * (k + 1) + 4));
        end
        // reset mid-stream with an op still being offered
        rst = 1'b0;
        drive_op(5'd20, 5'd0, 5'd6, 1'b1, 2'b10, 1'b1, 1'b0, 32'h900, 32'h0, 32'h0);
        step();
        chk("midrst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("midrst_upd_valid", {31'b0, upd_valid}, 32'd0);
        chk("midrst_addr", mem_address, 32'h0);
        input_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("postrst_mem_valid", {31'b0, mem_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
